rtdc_time_set_ctrl: RTL

- Controller that sequences the HH:MM:SS BCD timekeeping counter.
- Generates its 1 Hz advance enable from CLK via a prescaler.
- Runs a button-driven set-time state machine (hours, then minutes, then seconds) and commits the edited time through a one-cycle parallel LOAD.
- Sits between debounced front-panel buttons, the timekeeper and the display mux; the display mux uses EDIT/BLINK to flash the field being edited.

---
 rtl/rtdc_pkg.sv | 22 ++
 rtl/rtdc_time_set_ctrl_if.sv | 28 ++
 rtl/rtdc_bcd2_inc.sv | 19 +
 rtl/rtdc_time_set_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rtdc_pkg.sv
// Shared encodings for the RTDC set-time controller: FSM states, edit field codes, BCD limits.
package rtdc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RUN      = 3'd0;
  localparam state_t ST_EDIT_HR  = 3'd1;
  localparam state_t ST_EDIT_MIN = 3'd2;
  localparam state_t ST_EDIT_SEC = 3'd3;
  localparam state_t ST_COMMIT   = 3'd4;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_HR   = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_SEC  = 2'd3
  } edit_fld_e;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

endpackage

// File: rtl/rtdc_time_set_ctrl_if.sv
// Front-panel, timekeeper and display-mux signals of the set-time controller.
interface rtdc_time_set_ctrl_if;
  logic       BTN_MODE;
  logic       BTN_INC;
  logic [3:0] CUR_HRM, CUR_HRL, CUR_MIN_M, CUR_MIN_L, CUR_SEC_M, CUR_SEC_L;
  logic       TICK;
  logic       LOAD;
  logic [3:0] LD_HRM, LD_HRL, LD_MIN_M, LD_MIN_L, LD_SEC_M, LD_SEC_L;
  logic       SET_ACTIVE;
  logic [1:0] EDIT;
  logic       BLINK;

  modport master (
    output BTN_MODE, BTN_INC,
    output CUR_HRM, CUR_HRL, CUR_MIN_M, CUR_MIN_L, CUR_SEC_M, CUR_SEC_L,
    input  TICK, LOAD,
    input  LD_HRM, LD_HRL, LD_MIN_M, LD_MIN_L, LD_SEC_M, LD_SEC_L,
    input  SET_ACTIVE, EDIT, BLINK
  );

  modport slave (
    input  BTN_MODE, BTN_INC,
    input  CUR_HRM, CUR_HRL, CUR_MIN_M, CUR_MIN_L, CUR_SEC_M, CUR_SEC_L,
    output TICK, LOAD,
    output LD_HRM, LD_HRL, LD_MIN_M, LD_MIN_L, LD_SEC_M, LD_SEC_L,
    output SET_ACTIVE, EDIT, BLINK
  );
endinterface

// File: rtl/rtdc_bcd2_inc.sv
// Two-digit BCD +1 with wrap at MAX; any malformed or out-of-range value restarts at 00.
module rtdc_bcd2_inc #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val_i,
  output logic [7:0] nxt_o
);

  // Valid BCD preserves numeric order, so a plain compare against MAX is enough.
  always_comb begin
    if (val_i[7:4] > 4'd9 || val_i[3:0] > 4'd9 || val_i >= MAX)
      nxt_o = 8'h00;
    else if (val_i[3:0] == 4'd9)
      nxt_o = {val_i[7:4] + 4'd1, 4'd0};
    else
      nxt_o = {val_i[7:4], val_i[3:0] + 4'd1};
  end

endmodule

// File: rtl/rtdc_time_set_ctrl.sv
// 1 Hz prescaler plus button-driven HH:MM:SS set-time FSM feeding the timekeeper's parallel load.
//   state       | meaning
//   RUN         | clock free-running, TICK every second
//   EDIT_HR/MIN/SEC | timekeeper frozen, INC edits the shadow field
//   COMMIT      | one-cycle LOAD of the shadow time
module rtdc_time_set_ctrl
  import rtdc_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int TIMEOUT_S = 30
) (
  input  logic                 CLK,
  input  logic                 RST,
  rtdc_time_set_ctrl_if.slave  bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_S + 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [7:0]  hr_nxt, min_nxt, sec_nxt;
  logic        tick_q, tick_d;
  logic        load_q, load_d;
  logic [23:0] ld_q, ld_d;
  logic        sec_pulse, in_edit, any_btn;
  edit_fld_e   edit_c;

  rtdc_bcd2_inc #(.MAX(HR_MAX)) u_inc_hr  (.val_i(hr_q),  .nxt_o(hr_nxt));
  rtdc_bcd2_inc #(.MAX(MS_MAX)) u_inc_min (.val_i(min_q), .nxt_o(min_nxt));
  rtdc_bcd2_inc #(.MAX(MS_MAX)) u_inc_sec (.val_i(sec_q), .nxt_o(sec_nxt));

  assign sec_pulse = (cnt_q == CW'(TICK_DIV - 1));
  assign in_edit   = (state_q == ST_EDIT_HR) || (state_q == ST_EDIT_MIN) ||
                     (state_q == ST_EDIT_SEC);
  assign any_btn   = bus.BTN_MODE || bus.BTN_INC;

  always_comb begin
    state_d = state_q;
    cnt_d   = sec_pulse ? '0 : cnt_q + CW'(1);
    tmo_d   = tmo_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    load_d  = 1'b0;
    ld_d    = '0;
    case (state_q)
      ST_RUN: begin
        if (bus.BTN_MODE) begin
          hr_d    = {bus.CUR_HRM, bus.CUR_HRL};
          min_d   = {bus.CUR_MIN_M, bus.CUR_MIN_L};
          sec_d   = {bus.CUR_SEC_M, bus.CUR_SEC_L};
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_EDIT_HR;
        end
      end
      ST_EDIT_HR, ST_EDIT_MIN, ST_EDIT_SEC: begin
        if (any_btn)
          tmo_d = '0;
        else if (sec_pulse) begin
          if (tmo_q == TW'(TIMEOUT_S - 1)) begin
            tmo_d   = '0;
            state_d = ST_RUN;
          end else
            tmo_d = tmo_q + TW'(1);
        end
        if (bus.BTN_MODE) begin
          case (state_q)
            ST_EDIT_HR:  state_d = ST_EDIT_MIN;
            ST_EDIT_MIN: state_d = ST_EDIT_SEC;
            default: begin
              // Restart the prescaler here so the first TICK lands TICK_DIV cycles after LOAD.
              state_d = ST_COMMIT;
              load_d  = 1'b1;
              ld_d    = {hr_q, min_q, sec_q};
              cnt_d   = '0;
            end
          endcase
        end else if (bus.BTN_INC) begin
          case (state_q)
            ST_EDIT_HR:  hr_d  = hr_nxt;
            ST_EDIT_MIN: min_d = min_nxt;
            default:     sec_d = sec_nxt;
          endcase
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    // No advance on the cycle RUN is left, so the captured time stays exact.
    tick_d = sec_pulse && (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tmo_q   <= '0;
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      tick_q  <= 1'b0;
      load_q  <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      load_q  <= load_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_EDIT_HR:  edit_c = FLD_HR;
      ST_EDIT_MIN: edit_c = FLD_MIN;
      ST_EDIT_SEC: edit_c = FLD_SEC;
      default:     edit_c = FLD_NONE;
    endcase
  end

  assign bus.TICK       = tick_q;
  assign bus.LOAD       = load_q;
  assign bus.LD_HRM     = ld_q[23:20];
  assign bus.LD_HRL     = ld_q[19:16];
  assign bus.LD_MIN_M   = ld_q[15:12];
  assign bus.LD_MIN_L   = ld_q[11:8];
  assign bus.LD_SEC_M   = ld_q[7:4];
  assign bus.LD_SEC_L   = ld_q[3:0];
  assign bus.SET_ACTIVE = in_edit;
  assign bus.EDIT       = edit_c;
  assign bus.BLINK      = in_edit && (cnt_q < CW'(TICK_DIV / 2));

endmodule
